uart_freq_cmd: RTL and testbench

Command parser between the UART receiver and the DDS phase accumulator. It takes ASCII bytes from the receiver's `rx_data`/`rx_data_valid` stream and accumulates a decimal frequency in Hz, terminated by CR or LF. It range-checks the value and converts it to a 32-bit frequency tuning word, `floor(f * 2^32 / CLK_FRE_HZ)`, using a sequential restoring divider. The result goes to the DDS as `fre_word` with a one-cycle `fre_word_valid` strobe.

---
 rtl/uart_freq_cmd.sv | 190 +++++++++++++++++++
 tb/tb_uart_freq_cmd.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_freq_cmd.sv
// ASCII decimal frequency command parser feeding the DDS phase accumulator.
// Digits accumulate into Hz; CR/LF triggers a restoring divide into a 32-bit tuning word.
module uart_freq_cmd #(
  parameter int unsigned CLK_FRE_HZ   = 50_000_000,
  parameter int unsigned MAX_DIGITS   = 8,
  parameter logic [31:0] DEFAULT_WORD = 32'd356482
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [31:0] fre_word,
  output logic        fre_word_valid,
  output logic        busy,
  output logic        err,
  output logic        led
);

  localparam int unsigned ACC_W  = 27;
  localparam int unsigned REM_W  = 28;
  localparam int unsigned DBL_W  = REM_W + 1;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ITER_W = 5;
  localparam int unsigned CNT_W  = $clog2(MAX_DIGITS + 1);

  localparam logic [ACC_W-1:0]  ACC_MAX  = ACC_W'(CLK_FRE_HZ / 2);
  localparam logic [DBL_W-1:0]  DIVISOR  = DBL_W'(CLK_FRE_HZ);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_DIGITS);
  localparam logic [ITER_W-1:0] ITER_END = ITER_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_CALC,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [WORD_W-1:0]   quo_q, quo_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [WORD_W-1:0]   fre_word_q, fre_word_d;
  logic                fre_word_valid_q, fre_word_valid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                led_q, led_d;
  logic                rx_data_ready_q, rx_data_ready_d;

  logic                accept;
  logic                is_digit;
  logic                is_term;
  logic [DBL_W-1:0]    rem_dbl;
  logic [7:0]          digit_val;

  assign accept    = rx_data_valid && rx_data_ready_q;
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign digit_val = rx_data - 8'h30;
  assign rem_dbl   = {rem_q, 1'b0};

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      acc_q            <= '0;
      cnt_q            <= '0;
      ovf_q            <= 1'b0;
      rem_q            <= '0;
      quo_q            <= '0;
      iter_q           <= '0;
      fre_word_q       <= DEFAULT_WORD;
      fre_word_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      err_q            <= 1'b0;
      led_q            <= 1'b0;
      rx_data_ready_q  <= 1'b1;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      cnt_q            <= cnt_d;
      ovf_q            <= ovf_d;
      rem_q            <= rem_d;
      quo_q            <= quo_d;
      iter_q           <= iter_d;
      fre_word_q       <= fre_word_d;
      fre_word_valid_q <= fre_word_valid_d;
      busy_q           <= busy_d;
      err_q            <= err_d;
      led_q            <= led_d;
      rx_data_ready_q  <= rx_data_ready_d;
    end
  end

  // Parser, divider sequencing and next-output logic
  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    cnt_d            = cnt_q;
    ovf_d            = ovf_q;
    rem_d            = rem_q;
    quo_d            = quo_q;
    iter_d           = iter_q;
    fre_word_d       = fre_word_q;
    fre_word_valid_d = 1'b0;
    err_d            = 1'b0;
    led_d            = led_q;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            state_d = ST_ACCUM;
            if (cnt_q == CNT_MAX) begin
              ovf_d = 1'b1;
            end else begin
              acc_d = ACC_W'(acc_q * ACC_W'(10)) + ACC_W'(digit_val);
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_term) begin
            // A terminator with no digits (e.g. LF after CR) is silently dropped
            if (state_q == ST_ACCUM) begin
              if (ovf_q || (acc_q > ACC_MAX)) begin
                err_d   = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = ST_IDLE;
              end else begin
                rem_d   = REM_W'(acc_q);
                quo_d   = '0;
                iter_d  = '0;
                state_d = ST_CALC;
              end
            end
          end else begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_CALC: begin
        // One quotient bit per cycle, MSB first
        if (rem_dbl >= DIVISOR) begin
          rem_d = REM_W'(rem_dbl - DIVISOR);
          quo_d = {quo_q[WORD_W-2:0], 1'b1};
        end else begin
          rem_d = REM_W'(rem_dbl);
          quo_d = {quo_q[WORD_W-2:0], 1'b0};
        end
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_END) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        fre_word_d       = quo_q;
        fre_word_valid_d = 1'b1;
        led_d            = ~led_q;
        acc_d            = '0;
        cnt_d            = '0;
        ovf_d            = 1'b0;
        state_d          = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rx_data_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
    busy_d          = (state_d == ST_CALC) || (state_d == ST_DONE);
  end

  assign rx_data_ready  = rx_data_ready_q;
  assign fre_word       = fre_word_q;
  assign fre_word_valid = fre_word_valid_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign led            = led_q;

endmodule

// File: tb/tb_uart_freq_cmd.sv
// Bench for uart_freq_cmd: directed command table, timing corner sequences,
// and random commands checked against an arithmetic reference model.
module tb_uart_freq_cmd;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned MAX_DIG = 8;
  localparam logic [31:0] DEF_W   = 32'd356482;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_valid = 1'b0;
  logic        rx_data_ready;
  logic [31:0] fre_word;
  logic        fre_word_valid;
  logic        busy;
  logic        err;
  logic        led;

  uart_freq_cmd #(
    .CLK_FRE_HZ  (CLK_HZ),
    .MAX_DIGITS  (MAX_DIG),
    .DEFAULT_WORD(DEF_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .fre_word      (fre_word),
    .fre_word_valid(fre_word_valid),
    .busy          (busy),
    .err           (err),
    .led           (led)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  int vcyc     = 0;
  int acc_cyc  = 0;
  bit led_exp  = 1'b0;
  logic [31:0] cur_w = DEF_W;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping; valid and err must never coincide
  always @(negedge clk) begin
    if (rst_n && (fre_word_valid || err)) begin
      checks++;
      if (fre_word_valid && err) begin
        failures++;
        $display("FAIL valid_err_overlap: valid=%0b err=%0b required not both high", fre_word_valid, err);
      end
      if (fre_word_valid) begin
        vcnt++;
        vcyc = cyc;
      end
      if (err) ecnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_data_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_data_ready) begin
      chk("ready_timeout", 32'(rx_data_ready), 32'd1);
    end else begin
      rx_data       = b;
      rx_data_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      acc_cyc       = cyc;
      rx_data_valid = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic run_cmd(input string nm, input string s, input int ev, input int ee,
                         input logic [31:0] ew);
    int v0 = vcnt;
    int e0 = ecnt;
    send_str(s);
    repeat (40) @(negedge clk);
    chk({nm, "_valid_cnt"}, 32'(vcnt - v0), 32'(ev));
    chk({nm, "_err_cnt"}, 32'(ecnt - e0), 32'(ee));
    chk({nm, "_word"}, fre_word, ew);
    if (ev % 2 == 1) led_exp = ~led_exp;
    chk({nm, "_led"}, 32'(led), 32'(led_exp));
    chk({nm, "_ready"}, 32'(rx_data_ready), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    cur_w = ew;
  endtask

  // Reference: command rules applied to a character string with plain arithmetic
  task automatic model(input string s, inout logic [31:0] w, output int nv, output int ne);
    longint unsigned v = 0;
    int              n = 0;
    bit              ovf = 1'b0;
    byte             c;
    nv = 0;
    ne = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        if (n == MAX_DIG) ovf = 1'b1;
        else begin
          v = v * 10 + longint'(c - 8'h30);
          n++;
        end
      end else if (c == 8'h0D || c == 8'h0A) begin
        if (n != 0) begin
          if (ovf || v > longint'(CLK_HZ / 2)) ne++;
          else begin
            nv++;
            w = 32'((v << 32) / longint'(CLK_HZ));
          end
          v = 0; n = 0; ovf = 1'b0;
        end
      end else begin
        ne++;
        v = 0; n = 0; ovf = 1'b0;
      end
    end
  endtask

  typedef struct {
    string       name;
    string       cmd;
    int          ev;
    int          ee;
    logic [31:0] ew;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int          n;
    int          v0;
    int          e0;
    int          nv;
    int          ne;
    logic [31:0] w;
    string       s;

    tbl[0] = '{"f43000_crlf", "43000\015\012", 1, 0, 32'd3693671};
    tbl[1] = '{"f25M_max", "25000000\015", 1, 0, 32'h8000_0000};
    tbl[2] = '{"f1", "1\015", 1, 0, 32'd85};
    tbl[3] = '{"f0_dc", "0\015", 1, 0, 32'd0};
    tbl[4] = '{"range_err", "25000001\015", 0, 1, 32'd0};
    tbl[5] = '{"len_err", "123456789\015", 0, 1, 32'd0};
    tbl[6] = '{"bare_term", "\015\012", 0, 0, 32'd0};
    tbl[7] = '{"f1000_8dig", "00001000\015", 1, 0, 32'd85899};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_word", fre_word, DEF_W);
    chk("rst_ready", 32'(rx_data_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(fre_word_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_led", 32'(led), 32'd0);

    // 4150 Hz: latency and ready-low window
    v0 = vcnt;
    send_str("4150");
    send_byte(8'h0D);
    n = 0;
    while (!rx_data_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("ready_low_cycles", 32'(n), 32'd33);
    repeat (5) @(negedge clk);
    chk("latency", 32'(vcyc - acc_cyc), 32'd33);
    chk("f4150_valid_cnt", 32'(vcnt - v0), 32'd1);
    chk("f4150_word", fre_word, 32'd356482);
    led_exp = 1'b1;
    chk("f4150_led", 32'(led), 32'(led_exp));

    foreach (tbl[i]) run_cmd(tbl[i].name, tbl[i].cmd, tbl[i].ev, tbl[i].ee, tbl[i].ew);

    // Bad byte: err exactly in the cycle after acceptance, trailing CR ignored
    e0 = ecnt;
    v0 = vcnt;
    send_str("12");
    send_byte(8'h61);
    chk("bad_byte_err_hi", 32'(err), 32'd1);
    @(negedge clk);
    chk("bad_byte_err_lo", 32'(err), 32'd0);
    send_byte(8'h0D);
    repeat (40) @(negedge clk);
    chk("bad_byte_err_cnt", 32'(ecnt - e0), 32'd1);
    chk("bad_byte_valid_cnt", 32'(vcnt - v0), 32'd0);
    chk("bad_byte_word", fre_word, cur_w);
    run_cmd("after_bad", "1000\015", 1, 0, 32'd85899);

    // Reset during CALC aborts the conversion
    send_str("4150");
    send_byte(8'h0D);
    repeat (10) @(negedge clk);
    chk("midcalc_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midcalc_rst_word", fre_word, DEF_W);
    chk("midcalc_rst_ready", 32'(rx_data_ready), 32'd1);
    chk("midcalc_rst_busy", 32'(busy), 32'd0);
    chk("midcalc_rst_led", 32'(led), 32'd0);
    led_exp = 1'b0;
    v0 = vcnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("midcalc_no_valid", 32'(vcnt - v0), 32'd0);
    chk("midcalc_word", fre_word, DEF_W);
    cur_w = DEF_W;
    run_cmd("post_rst", "1000\015", 1, 0, 32'd85899);

    // Random commands against the reference model
    for (int k = 0; k < 40; k++) begin
      s = "";
      if ($urandom_range(0, 3) == 0) begin
        s = $sformatf("%0d", 25000000 + $urandom_range(0, 2) - 1);
      end else begin
        n = int'($urandom_range(1, 9));
        for (int d = 0; d < n; d++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
      end
      if ($urandom_range(0, 7) == 0) s = {s, "x", $sformatf("%0d", $urandom_range(0, 99))};
      case ($urandom_range(0, 2))
        0: s = {s, "\015"};
        1: s = {s, "\012"};
        default: s = {s, "\015\012"};
      endcase
      w = cur_w;
      model(s, w, nv, ne);
      run_cmd($sformatf("rand%0d", k), s, nv, ne, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
